// File: rtl/mmio_bus.sv
// mmio_bus: single-outstanding MMIO interconnect between the LSU and RAM/peripherals.
// Registered 1-cycle response; keyboard FIFO, switches, seg/LED, 64-bit RTC and a sticky error log.
module mmio_bus #(
    parameter int unsigned   AW       = 32,
    parameter int unsigned   DW       = 64,
    parameter logic [AW-1:0] RAM_BASE = 32'h8000_0000,
    parameter logic [AW-1:0] RAM_LEN  = 32'h0800_0000,
    parameter logic [AW-1:0] DEV_BASE = 32'ha000_0000,
    parameter int unsigned   KBW      = 16,
    parameter int unsigned   KB_DEPTH = 8,
    parameter int unsigned   LEDW     = 16,
    parameter int unsigned   CLKDIV   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_wstrb,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic            ram_en,
    output logic            ram_wen,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_wdata,
    output logic [DW/8-1:0] ram_wstrb,
    input  logic [DW-1:0]   ram_rdata,
    input  logic            kb_valid,
    input  logic [KBW-1:0]  kb_code,
    output logic            kb_ready,
    input  logic [7:0]      swt_in,
    output logic [31:0]     seg_out,
    output logic [LEDW-1:0] led_out,
    output logic            timer_irq,
    output logic [AW-1:0]   err_addr
);

    localparam int unsigned SW   = DW / 8;
    localparam int unsigned PTRW = $clog2(KB_DEPTH);
    localparam int unsigned CNTW = PTRW + 1;
    localparam int unsigned PSW  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    localparam logic [AW-1:0] OFF_KBD   = AW'(32'h00);
    localparam logic [AW-1:0] OFF_SWT   = AW'(32'h08);
    localparam logic [AW-1:0] OFF_SEG   = AW'(32'h10);
    localparam logic [AW-1:0] OFF_LED   = AW'(32'h18);
    localparam logic [AW-1:0] OFF_MTIME = AW'(32'h20);
    localparam logic [AW-1:0] OFF_MTCMP = AW'(32'h28);
    localparam logic [AW-1:0] OFF_ERR   = AW'(32'h30);

    typedef enum logic {
        S_IDLE,
        S_RESP
    } state_e;

    typedef enum logic [2:0] {
        R_KBD,
        R_SWT,
        R_SEG,
        R_LED,
        R_MTIME,
        R_MTCMP,
        R_ERR,
        R_NONE
    } reg_e;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int unsigned i = 0; i < SW; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return res;
    endfunction

    state_e            state_q, state_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              ram_pend_q, ram_pend_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [31:0]       seg_q, seg_d;
    logic [LEDW-1:0]   led_q, led_d;
    logic [PSW-1:0]    ps_q, ps_d;
    logic [63:0]       mtime_q, mtime_d;
    logic [63:0]       mtimecmp_q, mtimecmp_d;
    logic              irq_q, irq_d;
    logic              err_seen_q, err_seen_d;
    logic [AW-1:0]     err_addr_q, err_addr_d;
    logic [KBW-1:0]    kb_mem_q [KB_DEPTH];
    logic [KBW-1:0]    kb_mem_d [KB_DEPTH];
    logic [PTRW-1:0]   kb_wr_q, kb_wr_d;
    logic [PTRW-1:0]   kb_rd_q, kb_rd_d;
    logic [CNTW-1:0]   kb_cnt_q, kb_cnt_d;

    logic              acc;
    logic              ram_hit;
    logic [AW:0]       addr_x, ram_lo_x, ram_hi_x;
    logic [AW-1:0]     dev_off;
    reg_e              sel;
    logic              bad_acc;
    logic              kb_full, kb_push, kb_pop;

    assign acc = req_valid & (state_q == S_IDLE);

    // One extra bit so a region ending at the top of the address space does not wrap.
    assign addr_x   = {1'b0, req_addr};
    assign ram_lo_x = {1'b0, RAM_BASE};
    assign ram_hi_x = {1'b0, RAM_BASE} + {1'b0, RAM_LEN};
    assign ram_hit  = (addr_x >= ram_lo_x) && (addr_x < ram_hi_x);
    assign dev_off  = req_addr - DEV_BASE;

    always_comb begin
        sel = R_NONE;
        if (!ram_hit && (req_addr >= DEV_BASE)) begin
            case (dev_off)
                OFF_KBD:   sel = R_KBD;
                OFF_SWT:   sel = R_SWT;
                OFF_SEG:   sel = R_SEG;
                OFF_LED:   sel = R_LED;
                OFF_MTIME: sel = R_MTIME;
                OFF_MTCMP: sel = R_MTCMP;
                OFF_ERR:   sel = R_ERR;
                default:   sel = R_NONE;
            endcase
        end
        case (sel)
            R_KBD, R_SWT, R_MTIME: bad_acc = req_wen;
            R_SEG, R_LED:          bad_acc = ~req_wen;
            R_MTCMP, R_ERR:        bad_acc = 1'b0;
            default:               bad_acc = ~ram_hit;
        endcase
    end

    assign kb_full = (kb_cnt_q == CNTW'(KB_DEPTH));
    assign kb_push = kb_valid & ~kb_full;

    always_comb begin
        state_d     = acc ? S_RESP : S_IDLE;
        rsp_valid_d = acc;
        ram_pend_d  = acc & ram_hit & ~req_wen;
        rsp_err_d   = 1'b0;
        rdata_d     = rdata_q;
        seg_d       = seg_q;
        led_d       = led_q;
        mtimecmp_d  = mtimecmp_q;
        err_seen_d  = err_seen_q;
        err_addr_d  = err_addr_q;
        kb_pop      = 1'b0;

        if (ps_q == PSW'(CLKDIV - 1)) begin
            ps_d    = '0;
            mtime_d = mtime_q + 64'd1;
        end else begin
            ps_d    = ps_q + PSW'(1);
            mtime_d = mtime_q;
        end
        irq_d = (mtime_q >= mtimecmp_q);

        if (acc) begin
            rsp_err_d = bad_acc;
            rdata_d   = '0;
            if (bad_acc) begin
                if (!err_seen_q) begin
                    err_seen_d = 1'b1;
                    err_addr_d = req_addr;
                end
            end else begin
                case (sel)
                    R_KBD: begin
                        if (kb_cnt_q != '0) begin
                            kb_pop  = 1'b1;
                            rdata_d = DW'(kb_mem_q[kb_rd_q]);
                        end
                    end
                    R_SWT:   rdata_d = DW'(swt_in);
                    R_SEG:   seg_d = 32'(merge_bytes(DW'(seg_q), req_wdata, req_wstrb));
                    R_LED:   led_d = LEDW'(merge_bytes(DW'(led_q), req_wdata, req_wstrb));
                    R_MTIME: rdata_d = DW'(mtime_q);
                    R_MTCMP: begin
                        if (req_wen) mtimecmp_d = 64'(merge_bytes(DW'(mtimecmp_q), req_wdata, req_wstrb));
                        else         rdata_d    = DW'(mtimecmp_q);
                    end
                    R_ERR: begin
                        if (req_wen) err_seen_d = 1'b0;
                        else         rdata_d    = DW'({err_seen_q, err_addr_q});
                    end
                    default: ;
                endcase
            end
        end
    end

    // Pop is gated on the registered count, so a push into an empty FIFO is never popped the same cycle.
    always_comb begin
        kb_mem_d = kb_mem_q;
        kb_wr_d  = kb_wr_q;
        kb_rd_d  = kb_rd_q;
        kb_cnt_d = kb_cnt_q;
        if (kb_push) begin
            kb_mem_d[kb_wr_q] = kb_code;
            kb_wr_d           = kb_wr_q + PTRW'(1);
        end
        if (kb_pop) kb_rd_d = kb_rd_q + PTRW'(1);
        case ({kb_push, kb_pop})
            2'b10:   kb_cnt_d = kb_cnt_q + CNTW'(1);
            2'b01:   kb_cnt_d = kb_cnt_q - CNTW'(1);
            default: kb_cnt_d = kb_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            ram_pend_q  <= 1'b0;
            rdata_q     <= '0;
            seg_q       <= '0;
            led_q       <= '0;
            ps_q        <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            irq_q       <= 1'b0;
            err_seen_q  <= 1'b0;
            err_addr_q  <= '0;
            kb_mem_q    <= '{default: '0};
            kb_wr_q     <= '0;
            kb_rd_q     <= '0;
            kb_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            ram_pend_q  <= ram_pend_d;
            rdata_q     <= rdata_d;
            seg_q       <= seg_d;
            led_q       <= led_d;
            ps_q        <= ps_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            irq_q       <= irq_d;
            err_seen_q  <= err_seen_d;
            err_addr_q  <= err_addr_d;
            kb_mem_q    <= kb_mem_d;
            kb_wr_q     <= kb_wr_d;
            kb_rd_q     <= kb_rd_d;
            kb_cnt_q    <= kb_cnt_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    // RAM data arrives in the response cycle, so it bypasses the read-data register.
    assign rsp_rdata = ram_pend_q ? ram_rdata : rdata_q;
    assign ram_en    = acc & ram_hit;
    assign ram_wen   = req_wen;
    assign ram_addr  = req_addr;
    assign ram_wdata = req_wdata;
    assign ram_wstrb = req_wstrb;
    assign kb_ready  = ~kb_full;
    assign seg_out   = seg_q;
    assign led_out   = led_q;
    assign timer_irq = irq_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mmio_bus.sv
// tb_mmio_bus: directed self-checking bench for mmio_bus with hand-computed expectations.
`timescale 1ns/1ps
module tb_mmio_bus;

    localparam logic [31:0] A_KBD   = 32'ha000_0000;
    localparam logic [31:0] A_SWT   = 32'ha000_0008;
    localparam logic [31:0] A_SEG   = 32'ha000_0010;
    localparam logic [31:0] A_LED   = 32'ha000_0018;
    localparam logic [31:0] A_MTIME = 32'ha000_0020;
    localparam logic [31:0] A_MTCMP = 32'ha000_0028;
    localparam logic [31:0] A_ERR   = 32'ha000_0030;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_valid, rsp_err;
    logic [63:0] rsp_rdata;
    logic        ram_en, ram_wen;
    logic [31:0] ram_addr;
    logic [63:0] ram_wdata, ram_rdata;
    logic [7:0]  ram_wstrb;
    logic        kb_valid, kb_ready;
    logic [15:0] kb_code;
    logic [7:0]  swt_in;
    logic [31:0] seg_out;
    logic [15:0] led_out;
    logic        timer_irq;
    logic [31:0] err_addr;

    always #5 clk = ~clk;

    mmio_bus #(
        .AW(32), .DW(64), .RAM_BASE(32'h8000_0000), .RAM_LEN(32'h0800_0000),
        .DEV_BASE(32'ha000_0000), .KBW(16), .KB_DEPTH(8), .LEDW(16), .CLKDIV(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata),
        .kb_valid(kb_valid), .kb_code(kb_code), .kb_ready(kb_ready),
        .swt_in(swt_in), .seg_out(seg_out), .led_out(led_out),
        .timer_irq(timer_irq), .err_addr(err_addr)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference count of RTC ticks since reset release (CLKDIV = 1).
    logic [63:0] tb_mtime;
    always @(posedge clk) begin
        if (!rst_n) tb_mtime <= '0;
        else        tb_mtime <= tb_mtime + 64'd1;
    end

    logic        last_ram_en;
    logic [7:0]  last_ram_wstrb;
    logic [31:0] last_ram_addr;
    logic [63:0] last_rdata;
    logic        last_err;
    logic [63:0] mt_at_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic wen, input logic [31:0] addr, input logic [63:0] wd, input logic [7:0] st);
        int unsigned wait_n;
        wait_n    = 0;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = st;
        req_valid = 1'b1;
        while (!req_ready && wait_n < 8) begin
            tick();
            wait_n++;
        end
        if (!req_ready) check("ready_timeout", req_ready, 1);
        #1;
        last_ram_en    = ram_en;
        last_ram_wstrb = ram_wstrb;
        last_ram_addr  = ram_addr;
        mt_at_acc      = tb_mtime;
        tick();
        req_valid = 1'b0;
        kb_valid  = 1'b0;
        check("rsp_valid", rsp_valid, 1);
        check("busy_ready", req_ready, 0);
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        tick();
        check("rsp_pulse", rsp_valid, 0);
    endtask

    task automatic push(input logic [15:0] code);
        kb_valid = 1'b1;
        kb_code  = code;
        tick();
        kb_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] cmp;
        logic        rise_seen;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        ram_rdata = 64'hDEAD;
        kb_valid  = 1'b0;
        kb_code   = '0;
        swt_in    = 8'h5A;
        repeat (3) tick();

        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);
        check("rst_ready", req_ready, 1);
        check("rst_kb_ready", kb_ready, 1);
        check("rst_irq", timer_irq, 0);
        check("rst_seg", seg_out, 0);
        check("rst_led", led_out, 0);
        check("rst_err_addr", err_addr, 0);
        rst_n = 1'b1;

        // RTC reads right after reset: accepted with mtime 0, then 2 cycles later.
        bus(0, A_MTIME, 0, 0);
        check("mtime_rd0", last_rdata, 64'd0);
        bus(0, A_MTIME, 0, 0);
        check("mtime_rd2", last_rdata, 64'd2);

        // RAM path
        bus(0, 32'h8000_0010, 0, 0);
        check("ram_en", last_ram_en, 1);
        check("ram_addr", last_ram_addr, 32'h8000_0010);
        check("ram_rdata", last_rdata, 64'hDEAD);
        check("ram_rd_err", last_err, 0);
        bus(1, 32'h8000_0100, 64'h1111, 8'h0F);
        check("ram_wr_en", last_ram_en, 1);
        check("ram_wstrb", last_ram_wstrb, 8'h0F);
        check("ram_wr_rdata", last_rdata, 0);
        bus(0, 32'h87FF_FFF8, 0, 0);
        check("ram_top_en", last_ram_en, 1);
        check("ram_top_err", last_err, 0);

        // Errors and sticky log
        bus(0, 32'h1000_0000, 0, 0);
        check("err1", last_err, 1);
        check("err1_rdata", last_rdata, 0);
        check("err1_ram_en", last_ram_en, 0);
        check("err1_addr", err_addr, 32'h1000_0000);
        bus(0, 32'h2000_0000, 0, 0);
        check("err2", last_err, 1);
        check("err2_rdata", last_rdata, 0);
        check("err2_sticky", err_addr, 32'h1000_0000);
        bus(0, A_ERR, 0, 0);
        check("err_rd", last_rdata, 64'h1_1000_0000);
        check("err_rd_err", last_err, 0);
        bus(1, A_ERR, 0, 8'hFF);
        check("err_wr_err", last_err, 0);
        bus(0, A_ERR, 0, 0);
        check("err_clr_rd", last_rdata, 64'h0_1000_0000);
        bus(0, 32'h8800_0000, 0, 0);
        check("ram_past_err", last_err, 1);
        check("ram_past_en", last_ram_en, 0);
        check("err_relatch", err_addr, 32'h8800_0000);
        bus(0, 32'ha000_0004, 0, 0);
        check("misalign_err", last_err, 1);
        bus(0, A_ERR, 0, 0);
        check("err_rd2", last_rdata, 64'h1_8800_0000);

        // SEG / LED / SWT
        bus(1, A_SEG, 64'h1234_5678, 8'h03);
        check("seg_wr_err", last_err, 0);
        check("seg_wr_rdata", last_rdata, 0);
        check("seg_merge1", seg_out, 32'h0000_5678);
        bus(1, A_SEG, 64'hAABB_CCDD, 8'h0C);
        check("seg_merge2", seg_out, 32'hAABB_5678);
        bus(1, A_LED, 64'hFFFF, 8'hFF);
        check("led_wr", led_out, 16'hFFFF);
        bus(0, A_SEG, 0, 0);
        check("seg_rd_err", last_err, 1);
        check("seg_rd_rdata", last_rdata, 0);
        bus(1, A_SWT, 64'hFF, 8'hFF);
        check("swt_wr_err", last_err, 1);
        check("seg_no_side", seg_out, 32'hAABB_5678);
        bus(0, A_SWT, 0, 0);
        check("swt_rd", last_rdata, 64'h5A);
        swt_in = 8'hC3;
        bus(0, A_SWT, 0, 0);
        check("swt_rd2", last_rdata, 64'hC3);

        // Keyboard FIFO
        push(16'h001C);
        push(16'h0032);
        bus(0, A_KBD, 0, 0);
        check("kbd_1c", last_rdata, 64'h1C);
        bus(0, A_KBD, 0, 0);
        check("kbd_32", last_rdata, 64'h32);
        bus(0, A_KBD, 0, 0);
        check("kbd_empty", last_rdata, 0);
        kb_valid = 1'b1;
        kb_code  = 16'h0055;
        bus(0, A_KBD, 0, 0);
        check("kbd_empty_push", last_rdata, 0);
        bus(0, A_KBD, 0, 0);
        check("kbd_55", last_rdata, 64'h55);
        for (int i = 0; i < 8; i++) push(16'h00A0 + 16'(i));
        check("kb_full", kb_ready, 0);
        push(16'h0099);
        check("kb_full_hold", kb_ready, 0);
        kb_valid = 1'b1;
        kb_code  = 16'h0077;
        bus(0, A_KBD, 0, 0);
        check("kbd_a0", last_rdata, 64'hA0);
        check("kb_ready_after_pop", kb_ready, 1);
        for (int i = 1; i < 8; i++) begin
            bus(0, A_KBD, 0, 0);
            check("kbd_seq", last_rdata, 64'hA0 + 64'(i));
        end
        bus(0, A_KBD, 0, 0);
        check("kbd_dropped", last_rdata, 0);

        // RTC compare
        bus(1, A_MTCMP, 64'h0, 8'hF0);
        bus(0, A_MTCMP, 0, 0);
        check("mtcmp_merge", last_rdata, 64'h0000_0000_FFFF_FFFF);
        bus(0, A_MTIME, 0, 0);
        check("mtime_rd", last_rdata, mt_at_acc);
        cmp = last_rdata + 64'd10;
        bus(1, A_MTCMP, cmp, 8'hFF);
        bus(0, A_MTCMP, 0, 0);
        check("mtcmp_rd", last_rdata, cmp);
        check("irq_low", timer_irq, 0);
        rise_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("irq_track", timer_irq, 64'((tb_mtime - 64'd1) >= cmp));
            if (timer_irq && !rise_seen) begin
                rise_seen = 1'b1;
                check("irq_rise_time", tb_mtime, cmp + 64'd1);
            end
        end
        check("irq_rose", timer_irq, 1);

        // Reset while a response is pending
        push(16'h0042);
        req_wen   = 1'b0;
        req_addr  = A_SWT;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("pre_rst_valid", rsp_valid, 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_rdata", rsp_rdata, 0);
        check("mid_rst_err", rsp_err, 0);
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_seg", seg_out, 0);
        check("mid_rst_led", led_out, 0);
        check("mid_rst_kb_ready", kb_ready, 1);
        check("mid_rst_irq", timer_irq, 0);
        check("mid_rst_err_addr", err_addr, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", rsp_valid, 0);
        check("post_rst_irq", timer_irq, 0);
        bus(0, A_KBD, 0, 0);
        check("post_rst_kbd", last_rdata, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
